// File: rtl/adpll_lock_detect_pkg.sv
// Shared types and constants for the ADPLL lock detector and the filter-side blocks.
package adpll_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  localparam int CNT_W_DEF = 8;

  // Signed frequency error: one extra bit over the edge counters.
  localparam int ERR_W = CNT_W_DEF + 1;

  typedef logic signed [ERR_W-1:0] freq_err_t;

endpackage

// File: rtl/adpll_lock_detect_if.sv
// Monitor-side bundle: the two measured clocks and clear in, error/lock status out.
interface adpll_lock_detect_if #(
  parameter int CNT_W = adpll_pkg::CNT_W_DEF
);

  logic                   clk_ref;
  logic                   fb_clk;
  logic                   clr;
  logic signed [CNT_W:0]  freq_err;
  logic                   err_valid;
  logic                   locked;
  logic                   lost_lock;
  logic                   ref_lost;

  modport master (
    output clk_ref, fb_clk, clr,
    input  freq_err, err_valid, locked, lost_lock, ref_lost
  );

  modport slave (
    input  clk_ref, fb_clk, clr,
    output freq_err, err_valid, locked, lost_lock, ref_lost
  );

endinterface

// File: rtl/adpll_lock_detect_edge_sync.sv
// Three-flop synchronizer for an asynchronous clock input with a one-cycle
// rising-edge pulse taken between the second and third flops.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic edge_pulse
);

  logic [2:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], din};
    end
  end

  assign edge_pulse = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/adpll_lock_detect.sv
// Counts feedback edges over a window of reference edges, reports the signed
// frequency error per window and tracks lock with a SEARCH/LOCKED state machine.
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int WIN_LEN     = 64,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TOL         = 1,
  parameter int LOCK_WINS   = 4,
  parameter int UNLOCK_WINS = 2,
  parameter int TIMEOUT     = 1023
) (
  input logic               clk,
  input logic               rst_n,
  adpll_lock_detect_if.slave bus
);

  localparam int EW   = CNT_W + 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int GW   = $clog2(LOCK_WINS + 1);
  localparam int BW   = $clog2(UNLOCK_WINS + 1);

  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]      WIN_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic signed [EW-1:0]  WIN_S    = EW'(WIN_LEN);
  localparam logic signed [EW-1:0]  TOL_S    = EW'(TOL);
  localparam logic [TO_W-1:0]       TO_LIM   = TO_W'(TIMEOUT);
  localparam logic [GW-1:0]         GOOD_LAST = GW'(LOCK_WINS - 1);
  localparam logic [BW-1:0]         BAD_LAST  = BW'(UNLOCK_WINS - 1);

  // Bit 0: reference, bit 1: feedback.
  logic [1:0] async_in;
  logic [1:0] edge_vec;
  logic       ref_edge;
  logic       fb_edge;

  assign async_in = {bus.fb_clk, bus.clk_ref};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      edge_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.clr),
        .din        (async_in[gi]),
        .edge_pulse (edge_vec[gi])
      );
    end
  endgenerate

  assign ref_edge = edge_vec[0];
  assign fb_edge  = edge_vec[1];

  logic [CNT_W-1:0]     ref_cnt_reg, ref_cnt_next;
  logic [CNT_W-1:0]     fb_cnt_reg, fb_cnt_next;
  logic [CNT_W-1:0]     fb_final;
  logic [TO_W-1:0]      to_cnt_reg, to_cnt_next;
  logic signed [EW-1:0] freq_err_reg, freq_err_next;
  logic signed [EW-1:0] err_calc;
  logic                 err_valid_reg, err_valid_next;
  logic                 ref_lost_reg, ref_lost_next;
  logic                 win_close;
  logic                 to_hit;
  logic                 win_good;

  // An fb edge coinciding with the closing ref edge still belongs to this window.
  assign fb_final  = (fb_edge && (fb_cnt_reg != CNT_MAX)) ? fb_cnt_reg + 1'b1 : fb_cnt_reg;
  assign err_calc  = $signed({1'b0, fb_final}) - WIN_S;
  assign win_good  = (err_calc <= TOL_S) && (err_calc >= -TOL_S);
  assign win_close = ref_edge && (ref_cnt_reg == WIN_LAST);
  // Stays asserted while the reference is missing, holding the counters cleared.
  assign to_hit    = !ref_edge && (to_cnt_reg >= TO_LIM - 1'b1);

  always_comb begin
    ref_cnt_next   = ref_cnt_reg;
    fb_cnt_next    = fb_final;
    to_cnt_next    = to_cnt_reg;
    freq_err_next  = freq_err_reg;
    err_valid_next = 1'b0;
    ref_lost_next  = ref_lost_reg;
    if (ref_edge) begin
      to_cnt_next   = '0;
      ref_lost_next = 1'b0;
    end else if (to_cnt_reg != TO_LIM) begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end
    if (to_hit) begin
      ref_cnt_next  = '0;
      fb_cnt_next   = '0;
      ref_lost_next = 1'b1;
    end else if (win_close) begin
      ref_cnt_next   = '0;
      fb_cnt_next    = '0;
      freq_err_next  = err_calc;
      err_valid_next = 1'b1;
    end else if (ref_edge) begin
      ref_cnt_next = ref_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      ref_cnt_reg   <= '0;
      fb_cnt_reg    <= '0;
      to_cnt_reg    <= '0;
      freq_err_reg  <= '0;
      err_valid_reg <= 1'b0;
      ref_lost_reg  <= 1'b0;
    end else begin
      ref_cnt_reg   <= ref_cnt_next;
      fb_cnt_reg    <= fb_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      freq_err_reg  <= freq_err_next;
      err_valid_reg <= err_valid_next;
      ref_lost_reg  <= ref_lost_next;
    end
  end

  lock_state_t     state_reg, state_next;
  logic [GW-1:0]   good_cnt_reg, good_cnt_next;
  logic [BW-1:0]   bad_cnt_reg, bad_cnt_next;
  logic            lost_lock_reg, lost_lock_next;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      state_reg     <= SEARCH;
      good_cnt_reg  <= '0;
      bad_cnt_reg   <= '0;
      lost_lock_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      good_cnt_reg  <= good_cnt_next;
      bad_cnt_reg   <= bad_cnt_next;
      lost_lock_reg <= lost_lock_next;
    end
  end

  // Evaluated in the same edge that registers err_valid, so locked moves with it.
  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    bad_cnt_next   = bad_cnt_reg;
    lost_lock_next = 1'b0;
    if (to_hit) begin
      state_next     = SEARCH;
      good_cnt_next  = '0;
      bad_cnt_next   = '0;
      lost_lock_next = (state_reg == LOCKED);
    end else if (win_close) begin
      case (state_reg)
        SEARCH: begin
          if (!win_good) begin
            good_cnt_next = '0;
          end else if (good_cnt_reg == GOOD_LAST) begin
            state_next    = LOCKED;
            good_cnt_next = '0;
          end else begin
            good_cnt_next = good_cnt_reg + 1'b1;
          end
        end
        LOCKED: begin
          if (win_good) begin
            bad_cnt_next = '0;
          end else if (bad_cnt_reg == BAD_LAST) begin
            state_next     = SEARCH;
            bad_cnt_next   = '0;
            lost_lock_next = 1'b1;
          end else begin
            bad_cnt_next = bad_cnt_reg + 1'b1;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  assign bus.freq_err  = freq_err_reg;
  assign bus.err_valid = err_valid_reg;
  assign bus.locked    = (state_reg == LOCKED);
  assign bus.lost_lock = lost_lock_reg;
  assign bus.ref_lost  = ref_lost_reg;

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Scoreboard bench: two detectors (TOL=1 and TOL=2) share one random/directed
// stimulus; an edge-level model predicts every window result and timeout.
module tb_adpll_lock_detect;
  import adpll_pkg::*;

  localparam int WIN_LEN     = 64;
  localparam int CNT_W       = 8;
  localparam int LOCK_WINS   = 4;
  localparam int UNLOCK_WINS = 2;
  localparam int TIMEOUT     = 1023;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct {
    int err;
    bit locked;
    bit lost;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ref_lvl = 1'b0;
  logic fb_lvl = 1'b0;
  logic clr_lvl = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tol [2] = '{1, 2};
  exp_t evq [2][$];
  exp_t toq [2][$];

  adpll_lock_detect_if #(.CNT_W(CNT_W)) bus0 ();
  adpll_lock_detect_if #(.CNT_W(CNT_W)) bus1 ();

  assign bus0.clk_ref = ref_lvl;
  assign bus0.fb_clk  = fb_lvl;
  assign bus0.clr     = clr_lvl;
  assign bus1.clk_ref = ref_lvl;
  assign bus1.fb_clk  = fb_lvl;
  assign bus1.clr     = clr_lvl;

  adpll_lock_detect #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .TOL(1), .LOCK_WINS(LOCK_WINS),
                      .UNLOCK_WINS(UNLOCK_WINS), .TIMEOUT(TIMEOUT))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  adpll_lock_detect #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .TOL(2), .LOCK_WINS(LOCK_WINS),
                      .UNLOCK_WINS(UNLOCK_WINS), .TIMEOUT(TIMEOUT))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic signed [CNT_W:0] fe [2];
  logic ev [2], lk [2], ll [2], rl [2];
  assign fe[0] = bus0.freq_err;  assign fe[1] = bus1.freq_err;
  assign ev[0] = bus0.err_valid; assign ev[1] = bus1.err_valid;
  assign lk[0] = bus0.locked;    assign lk[1] = bus1.locked;
  assign ll[0] = bus0.lost_lock; assign ll[1] = bus1.lost_lock;
  assign rl[0] = bus0.ref_lost;  assign rl[1] = bus1.ref_lost;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (edge counting at input level) ----------------
  int m_ref = 0, m_fb = 0, m_last_ref = 0;
  bit m_lost = 0, prev_ref = 0, prev_fb = 0;
  int m_good [2] = '{0, 0};
  int m_bad  [2] = '{0, 0};
  bit m_lock [2] = '{0, 0};

  task automatic model_clear(int n);
    m_ref = 0; m_fb = 0; m_lost = 0; m_last_ref = n - 2;
    prev_ref = 0; prev_fb = 0;
    for (int d = 0; d < 2; d++) begin
      m_good[d] = 0; m_bad[d] = 0; m_lock[d] = 0;
    end
  endtask

  task automatic model_close(int n);
    int err;
    bit good;
    exp_t e;
    err = ((m_fb > CNT_MAX) ? CNT_MAX : m_fb) - WIN_LEN;
    for (int d = 0; d < 2; d++) begin
      good = (err <= tol[d]) && (err >= -tol[d]);
      e.lost = 0;
      if (!m_lock[d]) begin
        m_good[d] = good ? m_good[d] + 1 : 0;
        if (m_good[d] == LOCK_WINS) begin m_lock[d] = 1; m_good[d] = 0; end
      end else begin
        m_bad[d] = good ? 0 : m_bad[d] + 1;
        if (m_bad[d] == UNLOCK_WINS) begin m_lock[d] = 0; m_bad[d] = 0; e.lost = 1; end
      end
      e.err = err; e.locked = m_lock[d]; e.idx = n;
      evq[d].push_back(e);
    end
    m_ref = 0; m_fb = 0;
  endtask

  task automatic model_timeout(int n);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e.err = 0; e.locked = 0; e.lost = m_lock[d]; e.idx = n;
      m_lock[d] = 0; m_good[d] = 0; m_bad[d] = 0;
      toq[d].push_back(e);
    end
  endtask

  task automatic model_cycle(int n, bit r, bit f);
    bit rr, fr;
    rr = r && !prev_ref;
    fr = f && !prev_fb;
    prev_ref = r;
    prev_fb = f;
    if (rr) begin
      m_lost = 0; m_last_ref = n;
      if (fr) m_fb++;
      m_ref++;
      if (m_ref == WIN_LEN) model_close(n);
    end else if (m_lost || (n - m_last_ref) >= TIMEOUT) begin
      if (!m_lost) model_timeout(n);
      m_lost = 1; m_ref = 0; m_fb = 0;
    end else if (fr) begin
      m_fb++;
    end
  endtask

  // ---------------- stimulus ----------------
  int ref_per = 10, fb_per = 10, ref_ph = 0, fb_ph = 0;
  bit ref_run = 0, fb_run = 0, clr_drv = 0, rst_drv = 1;

  task automatic drive_cycle();
    int n;
    bit r, f;
    n = cyc + 1;
    r = ref_run && (ref_ph < ref_per / 2);
    f = fb_run && (fb_ph < fb_per / 2);
    if (ref_run) ref_ph = (ref_ph + 1) % ref_per;
    if (fb_run) fb_ph = (fb_ph + 1) % fb_per;
    ref_lvl = r; fb_lvl = f; clr_lvl = clr_drv; rst_n = rst_drv;
    if (clr_drv || !rst_drv) model_clear(n);
    else model_cycle(n, r, f);
  endtask

  task automatic run(int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      drive_cycle();
    end
  endtask

  task automatic start_ref(int per);
    ref_per = per; ref_ph = 0; ref_run = 1;
  endtask

  task automatic start_fb(int per, int off);
    fb_per = per; fb_ph = (per - (off % per)) % per; fb_run = 1;
  endtask

  task automatic do_clear(bit use_rst);
    ref_run = 0; fb_run = 0;
    run(4);
    if (use_rst) rst_drv = 0; else clr_drv = 1;
    run(1);
    rst_drv = 1; clr_drv = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk(use_rst ? "reset_outputs" : "clr_outputs", d,
          int'({fe[d], ev[d], lk[d], ll[d], rl[d]}), 0);
    drive_cycle();
  endtask

  task automatic run_until_ref(int target);
    for (int i = 0; i < 5000 && m_ref != target; i++) run(1);
  endtask

  // ---------------- monitor ----------------
  bit rl_prev [2] = '{0, 0};

  always @(negedge clk) begin
    exp_t e;
    bit rise;
    for (int d = 0; d < 2; d++) begin
      rise = (rl[d] === 1'b1) && !rl_prev[d];
      rl_prev[d] = (rl[d] === 1'b1);
      if (ev[d] === 1'b1) begin
        if (evq[d].size() == 0) begin
          chk("unexpected_err_valid", d, 1, 0);
        end else begin
          e = evq[d].pop_front();
          $display("win dut%0d cyc=%0d freq_err=%0d exp=%0d locked=%0b exp=%0b lost_lock=%0b",
                   d, cyc, int'(fe[d]), e.err, lk[d], e.locked, ll[d]);
          chk("freq_err", d, int'(fe[d]), e.err);
          chk("locked", d, int'(lk[d]), int'(e.locked));
          chk("lost_lock_win", d, int'(ll[d]), int'(e.lost));
          chk("err_valid_latency", d, cyc - e.idx, 2);
        end
      end
      if (rise) begin
        if (toq[d].size() == 0) begin
          chk("unexpected_ref_lost", d, 1, 0);
        end else begin
          e = toq[d].pop_front();
          $display("timeout dut%0d cyc=%0d locked=%0b lost_lock=%0b exp=%0b",
                   d, cyc, lk[d], ll[d], e.lost);
          chk("lost_lock_timeout", d, int'(ll[d]), int'(e.lost));
          chk("locked_timeout", d, int'(lk[d]), 0);
          chk("timeout_latency_ok", d, int'((cyc - e.idx) >= 1 && (cyc - e.idx) <= 3), 1);
        end
      end
      if ((ll[d] === 1'b1) && (ev[d] !== 1'b1) && !rise)
        chk("spurious_lost_lock", d, 1, 0);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    do_clear(1);

    // Matched 50-cycle clocks: zero error, lock on the 4th window.
    start_ref(50); start_fb(50, 0);
    run(5 * 3200 + 100);

    // Feedback fast by a period ratio of 50/48.
    start_fb(48, 0);
    run(4 * 3200 + 100);

    // Relock at a faster reference, then lose feedback right after a close.
    start_ref(10); start_fb(10, 0);
    run(8 * 640);
    run_until_ref(0);
    fb_run = 0;
    run(2 * 640 + 40);

    // Relock, then lose the reference entirely.
    start_fb(10, 0);
    run(6 * 640);
    ref_run = 0; fb_run = 0;
    run(TIMEOUT + 100);
    for (int d = 0; d < 2; d++) begin
      chk("ref_lost_set", d, int'(rl[d]), 1);
      chk("locked_after_timeout", d, int'(lk[d]), 0);
    end
    start_ref(10); start_fb(10, 0);
    run(5);
    for (int d = 0; d < 2; d++) chk("ref_lost_clear", d, int'(rl[d]), 0);
    run(6 * 640);

    // Very fast feedback: counter saturates.
    start_fb(2, 0);
    run(2 * 640 + 40);

    // Coincident fb/ref edges at close, then fb one cycle after each ref edge.
    do_clear(0);
    start_ref(10); start_fb(10, 0);
    run(2 * 640 + 40);
    do_clear(0);
    start_ref(10); start_fb(10, 1);
    run(2 * 640 + 40);

    // Random periods, phases and short reference stalls.
    for (int s = 0; s < 10; s++) begin
      int rp, fp, mode;
      rp = int'($urandom_range(4, 16));
      mode = int'($urandom_range(0, 2));
      if (mode == 0) fp = rp;
      else if (mode == 1) fp = rp + int'($urandom_range(0, 2)) - 1;
      else fp = int'($urandom_range(2, 24));
      start_ref(rp);
      start_fb(fp, int'($urandom_range(0, fp - 1)));
      run(int'($urandom_range(400, 1500)));
      if ($urandom_range(0, 1) == 1) begin
        ref_run = 0;
        run(int'($urandom_range(10, 60)));
      end
    end

    // Mid-window clear and reset at ref edge 30.
    start_ref(10); start_fb(10, 0);
    run(5 * 640);
    run_until_ref(30);
    do_clear(0);
    start_ref(10); start_fb(10, 0);
    run(2 * 640 + 40);
    run_until_ref(30);
    do_clear(1);
    start_ref(10); start_fb(10, 0);
    run(2 * 640 + 40);

    ref_run = 0; fb_run = 0;
    run(20);
    for (int d = 0; d < 2; d++) begin
      chk("pending_windows", d, evq[d].size(), 0);
      chk("pending_timeouts", d, toq[d].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
